stack_seq: RTL and testbench

Register-pair stack sequencer for the SAP-3 datapath. It accepts PUSH, POP, CALL and RET commands and drives the 16-bit register file's select, increment/decrement and write controls. It runs the byte-wide memory handshake that moves register pairs to and from the stack at SP. It sits between the control unit and the register file / memory bus, and is the consumer of the register file's ext and pair-select interface.

---
 rtl/stack_seq.sv | 206 ++++++++++++++++++++
 tb/tb_stack_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// stack_seq -- register-pair stack sequencer for the SAP-3 datapath.
//
// Executes PUSH / POP / CALL / RET by steering the 16-bit register file
// (read select, write/ext select, inc/dec, write enable) and running a
// byte-wide memory handshake at SP. One command is in flight at a time.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op 0=PUSH 1=POP 2=CALL 3=RET,
//   cmd_op, cmd_rp        cmd_rp 0=BC 1=DE 2=HL 3=WZ (PUSH/POP only)
//   rf_rd_sel, rf_rdata   register file read port (rdata combinational)
//   rf_wr_sel, rf_ext     write/ext select; ext 0=none 1=inc 2=dec 3=inc2
//   rf_we, rf_wdata       register file write
//   mem_req, mem_we,      memory cycle; completes on an edge with
//   mem_addr, mem_wdata,  mem_req && mem_ack, read byte sampled on that edge
//   mem_rdata, mem_ack
//   done                  one-cycle pulse in the first IDLE cycle after a command
//   dbg_state             current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE; cmd_op/cmd_rp are captured on that edge only.
// A memory cycle holds all outputs stable while mem_req is high and mem_ack low.

module stack_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_rp,
  output logic [4:0]  rf_rd_sel,
  output logic [4:0]  rf_wr_sel,
  output logic [1:0]  rf_ext,
  output logic        rf_we,
  output logic [15:0] rf_wdata,
  input  logic [15:0] rf_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_SRC = 3'd1,
    S_SP_DEC = 3'd2,
    S_MEM_WR = 3'd3,
    S_MEM_RD = 3'd4,
    S_SP_INC = 3'd5,
    S_RD_WZ  = 3'd6,
    S_WB     = 3'd7
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_CALL = 2'd2;

  localparam logic [4:0] SEL_WZ = 5'b10110;
  localparam logic [4:0] SEL_PC = 5'b11000;
  localparam logic [4:0] SEL_SP = 5'b11010;

  localparam logic [1:0] EXT_INC = 2'd1;
  localparam logic [1:0] EXT_DEC = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_phase;      // 1 = high byte, 0 = low byte
  logic        w_phase_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic [15:0] r_tmp;
  logic [1:0]  r_op;
  logic [1:0]  r_rp;
  logic        w_accept;
  logic        w_push_like;
  logic [4:0]  w_rp_sel;
  logic [4:0]  w_src_sel;
  logic [4:0]  w_dst_sel;

  assign cmd_ready   = (r_state == S_IDLE);
  assign w_accept    = cmd_valid && cmd_ready;
  // PUSH and CALL write high byte first; POP and RET read low byte first.
  assign w_push_like = (cmd_op == OP_PUSH) || (cmd_op == OP_CALL);
  assign w_rp_sel    = {1'b1, 1'b0, r_rp, 1'b0};
  assign w_src_sel   = (r_op == OP_PUSH) ? w_rp_sel : SEL_PC;
  assign w_dst_sel   = (r_op == OP_POP)  ? w_rp_sel : SEL_PC;
  assign done        = r_done;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
      r_done  <= 1'b0;
      r_tmp   <= 16'h0000;
      r_op    <= 2'd0;
      r_rp    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_op <= cmd_op;
        r_rp <= cmd_rp;
      end
      if (r_state == S_RD_SRC || r_state == S_RD_WZ) begin
        r_tmp <= rf_rdata;
      end else if (r_state == S_MEM_RD && mem_ack) begin
        if (r_phase) r_tmp[15:8] <= mem_rdata;
        else         r_tmp[7:0]  <= mem_rdata;
      end
    end
  end

  // Next-state: the phase bit flips after each completed memory byte, so
  // SP_DEC/SP_INC know whether a second byte is still outstanding.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_phase_nxt = w_push_like;
          w_state_nxt = w_push_like ? S_RD_SRC : S_MEM_RD;
        end
      end
      S_RD_SRC: w_state_nxt = S_SP_DEC;
      S_SP_DEC: w_state_nxt = S_MEM_WR;
      S_MEM_WR: begin
        if (mem_ack) begin
          if (r_phase) begin
            w_phase_nxt = 1'b0;
            w_state_nxt = S_SP_DEC;
          end else if (r_op == OP_CALL) begin
            w_state_nxt = S_RD_WZ;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_MEM_RD: begin
        if (mem_ack) begin
          w_phase_nxt = ~r_phase;
          w_state_nxt = S_SP_INC;
        end
      end
      S_SP_INC: w_state_nxt = r_phase ? S_MEM_RD : S_WB;
      S_RD_WZ:  w_state_nxt = S_WB;
      S_WB: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: every rf_*/mem_* output is a pure function of state.
  always_comb begin
    rf_rd_sel = 5'd0;
    rf_wr_sel = 5'd0;
    rf_ext    = 2'd0;
    rf_we     = 1'b0;
    rf_wdata  = 16'h0000;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    case (r_state)
      S_RD_SRC: rf_rd_sel = w_src_sel;
      S_SP_DEC: begin
        rf_wr_sel = SEL_SP;
        rf_ext    = EXT_DEC;
      end
      S_SP_INC: begin
        rf_wr_sel = SEL_SP;
        rf_ext    = EXT_INC;
      end
      S_MEM_WR: begin
        rf_rd_sel = SEL_SP;
        mem_addr  = rf_rdata;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = r_phase ? r_tmp[15:8] : r_tmp[7:0];
      end
      S_MEM_RD: begin
        rf_rd_sel = SEL_SP;
        mem_addr  = rf_rdata;
        mem_req   = 1'b1;
      end
      S_RD_WZ: rf_rd_sel = SEL_WZ;
      S_WB: begin
        rf_wr_sel = w_dst_sel;
        rf_we     = 1'b1;
        rf_wdata  = r_tmp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq -- directed bench for stack_seq with a behavioural register
// file, a byte memory with programmable wait states, and a write scoreboard.

module tb_stack_seq;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_rp;
  logic [4:0]  rf_rd_sel;
  logic [4:0]  rf_wr_sel;
  logic [1:0]  rf_ext;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        done;
  logic [2:0]  dbg_state;

  stack_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rp    (cmd_rp),
    .rf_rd_sel (rf_rd_sel),
    .rf_wr_sel (rf_wr_sel),
    .rf_ext    (rf_ext),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];   // {addr, data} of expected memory writes

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- register file model ----------------
  // pair index = sel[3:1]: 0 BC, 1 DE, 2 HL, 3 WZ, 4 PC, 5 SP
  localparam int P_BC = 0, P_DE = 1, P_HL = 2, P_WZ = 3, P_PC = 4, P_SP = 5;
  logic [15:0] pairs [0:7];
  logic        poke_en;
  logic [2:0]  poke_idx;
  logic [15:0] poke_val;

  assign rf_rdata = pairs[rf_rd_sel[3:1]];

  always @(posedge clk) begin
    if (poke_en) pairs[poke_idx] <= poke_val;
    else if (rf_we) pairs[rf_wr_sel[3:1]] <= rf_wdata;
    else begin
      case (rf_ext)
        2'd1: pairs[rf_wr_sel[3:1]] <= pairs[rf_wr_sel[3:1]] + 16'd1;
        2'd2: pairs[rf_wr_sel[3:1]] <= pairs[rf_wr_sel[3:1]] - 16'd1;
        2'd3: pairs[rf_wr_sel[3:1]] <= pairs[rf_wr_sel[3:1]] + 16'd2;
        default: ;
      endcase
    end
  end

  // ---------------- memory model ----------------
  logic [7:0] mem [0:65535];
  int waits = 0;
  int wcnt = 0;
  int wr_cnt = 0;
  int unstable = 0;
  logic        prev_wait;
  logic [15:0] prev_addr;

  assign mem_ack   = mem_req && (wcnt >= waits);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    logic [23:0] e;
    if (!rst && mem_req && mem_ack && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hFFFFFF;
      chk("mem_wr", {8'h00, mem_addr, mem_wdata}, {8'h00, e});
    end
  end

  // address must hold through wait cycles
  always @(posedge clk) begin
    if (!rst && prev_wait && (!mem_req || mem_addr != prev_addr)) unstable <= unstable + 1;
    prev_wait <= !rst && mem_req && !mem_ack;
    prev_addr <= mem_addr;
  end

  // ---------------- driver tasks ----------------
  task automatic set_pair(input int idx, input logic [15:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx[2:0]; poke_val = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Issue one command and return edges from accept to the IDLE re-entry.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] rp, output int lat);
    @(negedge clk);
    chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rp = rp;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_rp = ~rp;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int base;
    logic found;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_rp = 2'd0;
    poke_en = 1'b0; poke_idx = 3'd0; poke_val = 16'h0;
    for (int i = 0; i < 8; i++) pairs[i] = 16'h0;
    #13;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_rf", {16'd0, rf_rd_sel, rf_wr_sel, rf_ext, rf_we, 3'd0}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // PUSH BC, zero wait
    set_pair(P_SP, 16'h2000);
    set_pair(P_BC, 16'h1234);
    waits = 0;
    exp_q.push_back({16'h1FFF, 8'h12});
    exp_q.push_back({16'h1FFE, 8'h34});
    run_cmd(2'd0, 2'd0, lat);
    chk("push_lat", lat, 5);
    chk("push_sp", {16'd0, pairs[P_SP]}, 32'h1FFE);
    chk("push_q", exp_q.size(), 0);

    // POP DE, two wait cycles per access
    waits = 2;
    run_cmd(2'd1, 2'd1, lat);
    chk("pop_lat", lat, 9);
    chk("pop_de", {16'd0, pairs[P_DE]}, 32'h1234);
    chk("pop_sp", {16'd0, pairs[P_SP]}, 32'h2000);
    chk("pop_addr_stable", unstable, 0);

    // CALL
    waits = 0;
    set_pair(P_PC, 16'h0103);
    set_pair(P_WZ, 16'h4000);
    set_pair(P_SP, 16'h3000);
    exp_q.push_back({16'h2FFF, 8'h01});
    exp_q.push_back({16'h2FFE, 8'h03});
    run_cmd(2'd2, 2'd3, lat);
    chk("call_lat", lat, 7);
    chk("call_pc", {16'd0, pairs[P_PC]}, 32'h4000);
    chk("call_sp", {16'd0, pairs[P_SP]}, 32'h2FFE);
    chk("call_q", exp_q.size(), 0);

    // RET
    run_cmd(2'd3, 2'd0, lat);
    chk("ret_lat", lat, 5);
    chk("ret_pc", {16'd0, pairs[P_PC]}, 32'h0103);
    chk("ret_sp", {16'd0, pairs[P_SP]}, 32'h3000);

    // PUSH HL with SP wrap
    set_pair(P_SP, 16'h0000);
    set_pair(P_HL, 16'hABCD);
    exp_q.push_back({16'hFFFF, 8'hAB});
    exp_q.push_back({16'hFFFE, 8'hCD});
    run_cmd(2'd0, 2'd2, lat);
    chk("wrap_lat", lat, 5);
    chk("wrap_sp", {16'd0, pairs[P_SP]}, 32'hFFFE);
    chk("wrap_q", exp_q.size(), 0);

    // Reset during the second MEM_WR of a PUSH
    set_pair(P_SP, 16'h2000);
    set_pair(P_BC, 16'h5678);
    waits = 3;
    exp_q.push_back({16'h1FFF, 8'h56});
    base = wr_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rp = 2'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (wr_cnt == base + 1 && mem_req) begin found = 1'b1; break; end
    end
    chk("rst_reach_wr2", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_mid_state", {29'd0, dbg_state}, 32'd0);
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      chk("rst_mid_nodone", {31'd0, done}, 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("rst_after_nodone", {31'd0, done}, 32'd0);
    end
    chk("rst_q", exp_q.size(), 0);
    chk("rst_sp", {16'd0, pairs[P_SP]}, 32'h1FFE);

    // POP BC after reset: low byte from the earlier PUSH, high byte 0x56
    waits = 0;
    run_cmd(2'd1, 2'd0, lat);
    chk("pop2_lat", lat, 5);
    chk("pop2_bc", {16'd0, pairs[P_BC]}, 32'h5634);
    chk("pop2_sp", {16'd0, pairs[P_SP]}, 32'h2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
